// File: rtl/bcd_request_arbiter_if.sv
// bcd_request_arbiter_if: requester and encoder signals of the shared BCD encoder arbiter.
//   master: arbiter side (drives ready/response/encoder command/status).
//   slave : requesters + encoder side (drives requests and encoder results).
interface bcd_request_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*LEN_W-1:0]  req_length;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [31:0]               rsp_bcd;
    logic                      rsp_high;
    logic                      rsp_timeout;
    logic                      enc_start;
    logic [DATA_W-1:0]         enc_binary;
    logic [LEN_W-1:0]          enc_length;
    logic                      enc_done;
    logic [31:0]               enc_bcd;
    logic                      enc_high;
    logic                      busy;
    logic [2:0]                grant_id;

    modport master (
        input  req_valid, req_data, req_length, enc_done, enc_bcd, enc_high,
        output req_ready, rsp_valid, rsp_bcd, rsp_high, rsp_timeout,
               enc_start, enc_binary, enc_length, busy, grant_id
    );

    modport slave (
        output req_valid, req_data, req_length, enc_done, enc_bcd, enc_high,
        input  req_ready, rsp_valid, rsp_bcd, rsp_high, rsp_timeout,
               enc_start, enc_binary, enc_length, busy, grant_id
    );
endinterface

// File: rtl/bcd_request_arbiter.sv
// bcd_request_arbiter: round-robin sharing of one BCD encoder between NUM_REQ requesters.
//   i_clock : system clock, rising edge
//   i_reset : asynchronous active-high reset
//   bus     : requester handshake (req_*/rsp_*), encoder command/result (enc_*), busy, grant_id
module bcd_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64
) (
    input logic                  i_clock,
    input logic                  i_reset,
    bcd_request_arbiter_if.master bus
);
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t              r_state, w_next;
    logic [2:0]          r_ptr, r_grant, w_off, w_win, w_ptr_nxt;
    logic [3:0]          w_sum;
    logic [DATA_W-1:0]   r_binary, w_data;
    logic [LEN_W-1:0]    r_length, w_len_raw, w_len;
    logic [WD_W-1:0]     r_wd;
    logic [31:0]         r_bcd;
    logic                r_high, r_timeout, w_found, w_expired;
    logic [2*NUM_REQ-1:0] w_rot;

    // Rotate the request vector so the pointer position lands at bit 0; the
    // lowest set bit is then the round-robin winner's offset from the pointer.
    assign w_rot     = {bus.req_valid, bus.req_valid} >> r_ptr;
    assign w_found   = |bus.req_valid;
    assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win     = (w_sum >= 4'(NUM_REQ)) ? 3'(w_sum - 4'(NUM_REQ)) : w_sum[2:0];
    assign w_ptr_nxt = (w_win == 3'(NUM_REQ - 1)) ? 3'd0 : w_win + 3'd1;
    assign w_len     = (w_len_raw > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : w_len_raw;
    assign w_expired = (r_wd == WD_W'(TIMEOUT - 1));

    always_comb begin
        w_off     = '0;
        w_data    = '0;
        w_len_raw = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (w_rot[i]) w_off = 3'(i);
        for (int k = 0; k < NUM_REQ; k++)
            if (w_win == 3'(k)) begin
                w_data    = bus.req_data[k*DATA_W +: DATA_W];
                w_len_raw = bus.req_length[k*LEN_W +: LEN_W];
            end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_ready[k] = (r_state == IDLE) && w_found && (w_win == 3'(k));
            bus.rsp_valid[k] = (r_state == RESPOND) && (r_grant == 3'(k));
        end
    end

    // A zero-length operand still passes through ISSUE (without a start
    // pulse) so the bypass response keeps a fixed two-cycle latency.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_found ? ISSUE : IDLE;
            ISSUE:   w_next = (r_length == '0) ? RESPOND : WAIT;
            WAIT:    w_next = (bus.enc_done || w_expired) ? RESPOND : WAIT;
            RESPOND: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_binary  <= '0;
            r_length  <= '0;
            r_wd      <= '0;
            r_bcd     <= '0;
            r_high    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (w_found) begin
                    r_ptr    <= w_ptr_nxt;
                    r_grant  <= w_win;
                    r_binary <= w_data;
                    r_length <= w_len;
                end
                ISSUE: begin
                    r_wd <= '0;
                    if (r_length == '0) begin
                        r_bcd     <= '0;
                        r_high    <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                WAIT: begin
                    r_wd <= r_wd + 1'b1;
                    if (bus.enc_done) begin
                        r_bcd     <= bus.enc_bcd;
                        r_high    <= bus.enc_high;
                        r_timeout <= 1'b0;
                    end else if (w_expired) begin
                        r_bcd     <= '0;
                        r_high    <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.enc_start   = (r_state == ISSUE) && (r_length != '0);
    assign bus.enc_binary  = r_binary;
    assign bus.enc_length  = r_length;
    assign bus.rsp_bcd     = r_bcd;
    assign bus.rsp_high    = r_high;
    assign bus.rsp_timeout = r_timeout;
    assign bus.busy        = (r_state != IDLE);
    assign bus.grant_id    = r_grant;
endmodule

// File: tb/tb_bcd_request_arbiter.sv
// tb_bcd_request_arbiter: directed and randomized transactions against a transaction-level reference model.
module tb_bcd_request_arbiter;
    localparam int N  = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stale_done = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   ptr = 0;
    int   e_delay = 0;
    int   e_cnt = -1;
    logic [32:0] e_res = '0;
    logic [31:0] e_noise = 32'h5A5A_A5A5;
    logic [31:0] req_d [N];
    int          req_l [N];

    always #5 clk = ~clk;

    bcd_request_arbiter_if #(.NUM_REQ(N), .DATA_W(32), .LEN_W(8)) bus ();

    bcd_request_arbiter #(.NUM_REQ(N), .DATA_W(32), .LEN_W(8), .TIMEOUT(TO)) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus)
    );

    // Behavioural encoder: binary (masked to length) to 8 decimal digits,
    // high when the value needs more than 8 digits.
    function automatic logic [32:0] enc_model(input logic [31:0] b, input int len);
        longint v;
        logic [31:0] r;
        logic h;
        v = (len >= 32) ? longint'(b) : (longint'(b) & ((64'sd1 <<< len) - 1));
        h = (v > 99999999);
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {h, r};
    endfunction

    // Done fires e_delay cycles after the start pulse; e_delay of 0 means never.
    always @(posedge clk or posedge rst) begin
        if (rst) e_cnt <= -1;
        else begin
            e_noise <= $urandom;
            if (bus.enc_start) begin
                e_cnt <= e_delay - 1;
                e_res <= enc_model(bus.enc_binary, int'(bus.enc_length));
            end else if (e_cnt > 0) e_cnt <= e_cnt - 1;
            else if (e_cnt == 0) e_cnt <= -1;
        end
    end

    assign bus.enc_done = (e_cnt == 0) | stale_done;
    assign bus.enc_bcd  = (e_cnt == 0) ? e_res[31:0] : e_noise;
    assign bus.enc_high = (e_cnt == 0) ? e_res[32] : e_noise[0];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction starting from IDLE at posedge+1 of the acceptance cycle.
    task automatic txn(input logic [3:0] v, input int d);
        int w, L, cyc, exp_cyc, idx;
        logic tmo;
        logic [32:0] ev;
        w = -1;
        for (int i = 0; i < N; i++) begin
            idx = (ptr + i) % N;
            if (w < 0 && v[idx[1:0]]) w = idx;
        end
        L = (req_l[w] > 32) ? 32 : req_l[w];
        for (int i = 0; i < N; i++) begin
            bus.req_data[i*32 +: 32] = req_d[i];
            bus.req_length[i*8 +: 8] = 8'(req_l[i]);
        end
        bus.req_valid = v;
        e_delay = d;
        #1;
        chk("ready", 64'(bus.req_ready), 64'(4'b0001 << w));
        chk("busy_idle", 64'(bus.busy), 0);
        @(posedge clk); #1;
        chk("grant_id", 64'(bus.grant_id), 64'(w));
        chk("enc_binary", 64'(bus.enc_binary), 64'(req_d[w]));
        chk("enc_length", 64'(bus.enc_length), 64'(L));
        chk("enc_start", 64'(bus.enc_start), 64'(L != 0));
        chk("ready_busy", 64'(bus.req_ready), 0);
        tmo = (L != 0) && !(d != 0 && d <= TO);
        exp_cyc = (L == 0) ? 2 : tmo ? 2 + TO : 2 + d;
        ev = (L == 0 || tmo) ? 33'd0 : enc_model(req_d[w], L);
        cyc = 1;
        while (bus.rsp_valid == '0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 2) chk("start_once", 64'(bus.enc_start), 0);
        end
        chk("rsp_cycle", 64'(cyc), 64'(exp_cyc));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(4'b0001 << w));
        chk("rsp_bcd", 64'(bus.rsp_bcd), 64'(ev[31:0]));
        chk("rsp_high", 64'(bus.rsp_high), 64'(ev[32]));
        chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(tmo));
        ptr = (w + 1) % N;
        @(posedge clk); #1;
        chk("rsp_pulse", 64'(bus.rsp_valid), 0);
        chk("rsp_hold", 64'(bus.rsp_bcd), 64'(ev[31:0]));
        bus.req_valid = '0;
    endtask

    initial begin
        int cnt, r, d;
        logic [3:0] v;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.req_length = '0;
        for (int i = 0; i < N; i++) begin
            req_d[i] = 32'd1000 + 32'(i);
            req_l[i] = 16;
        end
        @(posedge clk); #1;
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
        chk("rst_rsp_bcd", 64'(bus.rsp_bcd), 0);
        chk("rst_grant", 64'(bus.grant_id), 0);
        chk("rst_enc_binary", 64'(bus.enc_binary), 0);
        chk("rst_enc_length", 64'(bus.enc_length), 0);
        chk("rst_enc_start", 64'(bus.enc_start), 0);
        chk("rst_timeout", 64'(bus.rsp_timeout), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) txn(4'b1111, 3 + i);

        req_d[0] = 32'd12345678; req_l[0] = 24;
        txn(4'b0001, 20);

        req_d[2] = 32'hFFFF_FFFF; req_l[2] = 0;
        txn(4'b0100, 5);

        req_d[1] = 32'd87654321; req_l[1] = 40;
        txn(4'b0010, 7);

        txn(4'b0001, 0);
        req_d[3] = 32'd99999999; req_l[3] = 32;
        txn(4'b1000, TO);
        txn(4'b1000, TO + 1);

        stale_done = 1'b1;
        @(posedge clk); #1;
        stale_done = 1'b0;
        chk("stale_idle", 64'({bus.busy, bus.rsp_valid}), 0);
        req_l[1] = 20;
        txn(4'b0010, 10);

        bus.req_valid = 4'b0010;
        e_delay = 30;
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (6) begin @(posedge clk); #1; end
        chk("pre_rst_busy", 64'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 0);
        chk("mid_rst_outs", 64'({bus.grant_id, bus.enc_length, bus.enc_start, bus.rsp_valid}), 0);
        chk("mid_rst_bin", 64'(bus.enc_binary), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ptr = 0;
        cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.rsp_valid != '0) cnt++;
        end
        chk("no_rsp_after_rst", 64'(cnt), 0);
        txn(4'b0110, 6);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < N; i++) begin
                req_d[i] = $urandom;
                r = $urandom_range(0, 9);
                req_l[i] = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(33, 255)) : int'($urandom_range(1, 32));
            end
            r = $urandom_range(0, 9);
            d = (r == 0) ? 0 : (r == 1) ? TO : (r == 2) ? TO + 1 : int'($urandom_range(1, 25));
            v = 4'($urandom_range(1, 15));
            if (r == 3) begin
                stale_done = 1'b1;
                @(posedge clk); #1;
                stale_done = 1'b0;
            end
            txn(v, d);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
